// File: rtl/pattern_bank.sv
// pattern_bank: NBUFS x DEPTH x WIDTH pattern store with a serial shift port, a byte field port and a full-buffer view.
// Optional build macro PATTERN_BANK_ONEHOT_CHECK_EN enables strict one-hot checking of buffer_select/bufp.
module pattern_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 22,
  parameter int NBUFS = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = $clog2(NBUFS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sclk_en,
  input  logic                     ssel,
  input  logic [SW-1:0]            saddr,
  input  logic                     sin,
  output logic                     sout,
  input  logic [NBUFS-1:0]         buffer_select,
  output logic [DEPTH*WIDTH-1:0]   current_buffer,
  input  logic [NBUFS-1:0]         bufp,
  input  logic [AW-1:0]            fieldp,
  output logic [WIDTH-1:0]         field_byte,
  input  logic [AW-1:0]            fieldwp,
  input  logic [WIDTH-1:0]         field_in,
  input  logic                     field_write,
  input  logic                     err_clr,
  output logic                     sel_err
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [SW:0] NBUFS_L = (SW+1)'(NBUFS);

  logic [WIDTH-1:0]       mem_q [NBUFS][DEPTH];
  logic [WIDTH-1:0]       mem_d [NBUFS][DEPTH];
  logic [DEPTH*WIDTH-1:0] current_buffer_q, current_buffer_d;
  logic [WIDTH-1:0]       field_byte_q, field_byte_d;
  logic                   sel_err_q, sel_err_d;

  logic                   cb_ok_s, bp_ok_s, oh_err_s;
  logic [SW-1:0]          cb_idx_s, bp_idx_s, sidx_s;
  logic                   saddr_ok_s, rd_oob_s, wr_oob_s;
  logic                   wr_en_s, sh_req_s, sh_en_s, collide_s, err_set_s;
  logic [DEPTH*WIDTH-1:0] sh_flat_s, sh_next_s;

  // Returns {valid, index}; the lowest set bit wins and all-zero maps to the last buffer.
  function automatic logic [SW:0] sel_decode(input logic [NBUFS-1:0] v);
    logic [SW-1:0] idx;
    logic          ok;
    idx = SW'(NBUFS-1);
    for (int i = NBUFS-1; i >= 0; i--) begin
      if (v[i]) begin
        idx = SW'(i);
      end else begin
        idx = idx;
      end
    end
`ifdef PATTERN_BANK_ONEHOT_CHECK_EN
    ok = (v != {NBUFS{1'b0}}) && ((v & (v - NBUFS'(1))) == {NBUFS{1'b0}});
`else
    ok = 1'b1;
`endif
    return {ok, idx};
  endfunction

  assign {cb_ok_s, cb_idx_s} = sel_decode(buffer_select);
  assign {bp_ok_s, bp_idx_s} = sel_decode(bufp);

`ifdef PATTERN_BANK_ONEHOT_CHECK_EN
  assign oh_err_s = ~cb_ok_s | ~bp_ok_s;
`else
  assign oh_err_s = 1'b0;
`endif

  assign saddr_ok_s = ({1'b0, saddr} < NBUFS_L);
  assign sidx_s     = saddr_ok_s ? saddr : {SW{1'b0}};
  assign rd_oob_s   = ({1'b0, fieldp} >= DEPTH_L);
  assign wr_oob_s   = ({1'b0, fieldwp} >= DEPTH_L);
  assign wr_en_s    = field_write & ~wr_oob_s & bp_ok_s;
  assign sh_req_s   = ssel & sclk_en & saddr_ok_s;
  // A field write and a shift on the same buffer: the write wins and the shift is lost.
  assign collide_s  = sh_req_s & wr_en_s & (bp_idx_s == saddr);
  assign sh_en_s    = sh_req_s & ~collide_s;
  assign err_set_s  = collide_s | rd_oob_s | (field_write & wr_oob_s) | oh_err_s;

  assign sout = (ssel & saddr_ok_s) ? mem_q[sidx_s][DEPTH-1][WIDTH-1] : 1'b0;

  // Flatten the shift target so the whole buffer moves as one DEPTH*WIDTH shift register.
  always_comb begin
    sh_flat_s = {DEPTH*WIDTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      sh_flat_s[k*WIDTH +: WIDTH] = mem_q[sidx_s][k];
    end
    sh_next_s = {sh_flat_s[DEPTH*WIDTH-2:0], sin};
  end

  // Storage next state: shift first, then the field write overrides its byte.
  always_comb begin
    mem_d = mem_q;
    if (sh_en_s) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_d[sidx_s][k] = sh_next_s[k*WIDTH +: WIDTH];
      end
    end else begin
      mem_d = mem_q;
    end
    if (wr_en_s) begin
      mem_d[bp_idx_s][fieldwp] = field_in;
    end else begin
      mem_d[bp_idx_s][0] = mem_d[bp_idx_s][0];
    end
  end

  // Full-buffer view samples pre-edge storage; an invalid select holds it.
  always_comb begin
    current_buffer_d = current_buffer_q;
    if (cb_ok_s) begin
      for (int k = 0; k < DEPTH; k++) begin
        current_buffer_d[k*WIDTH +: WIDTH] = mem_q[cb_idx_s][k];
      end
    end else begin
      current_buffer_d = current_buffer_q;
    end
  end

  // Field read returns old data on a same-cycle write and zero for an out-of-range index.
  always_comb begin
    field_byte_d = field_byte_q;
    if (rd_oob_s) begin
      field_byte_d = {WIDTH{1'b0}};
    end else if (bp_ok_s) begin
      field_byte_d = mem_q[bp_idx_s][fieldp];
    end else begin
      field_byte_d = field_byte_q;
    end
  end

  // Sticky error: a set in the same cycle as a clear keeps it set.
  always_comb begin
    sel_err_d = sel_err_q;
    if (err_set_s) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end else begin
      sel_err_d = sel_err_q;
    end
  end

  // State registers; reset clears everything at once, aborting any shift in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBUFS; b++) begin
        for (int k = 0; k < DEPTH; k++) begin
          mem_q[b][k] <= {WIDTH{1'b0}};
        end
      end
      current_buffer_q <= {DEPTH*WIDTH{1'b0}};
      field_byte_q     <= {WIDTH{1'b0}};
      sel_err_q        <= 1'b0;
    end else begin
      mem_q            <= mem_d;
      current_buffer_q <= current_buffer_d;
      field_byte_q     <= field_byte_d;
      sel_err_q        <= sel_err_d;
    end
  end

  assign current_buffer = current_buffer_q;
  assign field_byte     = field_byte_q;
  assign sel_err        = sel_err_q;

endmodule

// File: tb/tb_pattern_bank.sv
// Directed self-checking bench for pattern_bank at default parameters (WIDTH=8, DEPTH=22, NBUFS=8).
module tb_pattern_bank;
  localparam int WIDTH = 8;
  localparam int DEPTH = 22;
  localparam int NBUFS = 8;
  localparam int AW = 5;
  localparam int SW = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   sclk_en, ssel, sin, sout;
  logic [SW-1:0]          saddr;
  logic [NBUFS-1:0]       buffer_select, bufp;
  logic [DEPTH*WIDTH-1:0] current_buffer;
  logic [AW-1:0]          fieldp, fieldwp;
  logic [WIDTH-1:0]       field_byte, field_in;
  logic                   field_write, err_clr, sel_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pattern_bank dut (
    .clk(clk), .rst_n(rst_n), .sclk_en(sclk_en), .ssel(ssel), .saddr(saddr),
    .sin(sin), .sout(sout), .buffer_select(buffer_select), .current_buffer(current_buffer),
    .bufp(bufp), .fieldp(fieldp), .field_byte(field_byte), .fieldwp(fieldwp),
    .field_in(field_in), .field_write(field_write), .err_clr(err_clr), .sel_err(sel_err)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle;
    ssel = 1'b0; sclk_en = 1'b0; sin = 1'b0; field_write = 1'b0; err_clr = 1'b0;
  endtask

  task automatic shift_in(input logic [SW-1:0] a, input logic [7:0] pat, input int n);
    ssel = 1'b1; saddr = a;
    for (int i = 0; i < n; i++) begin
      sclk_en = 1'b1; sin = pat[7 - (i % 8)];
      tick();
    end
    sclk_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; idle();
    saddr = 3'd0; buffer_select = 8'h01; bufp = 8'h01;
    fieldp = 5'd0; fieldwp = 5'd0; field_in = 8'h00;
    repeat (2) @(negedge clk);
    total++; if (current_buffer !== {DEPTH*WIDTH{1'b0}}) begin bad++; $display("FAIL reset_cb got=%h want=0", current_buffer); end
    total++; if (field_byte !== 8'h00) begin bad++; $display("FAIL reset_fb got=%h want=00", field_byte); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", sel_err); end
    rst_n = 1'b1;
    tick();
    total++; if (sout !== 1'b0) begin bad++; $display("FAIL reset_sout got=%b want=0", sout); end
    total++; if (field_byte !== 8'h00) begin bad++; $display("FAIL post_reset_fb got=%h want=00", field_byte); end
  endtask

  task automatic test_shift;
    logic [DEPTH*WIDTH-1:0] exp;
    exp = {DEPTH{8'hA5}};
    buffer_select = 8'h08;
    ssel = 1'b1; saddr = 3'd3;
    for (int i = 0; i < 176; i++) begin
      sclk_en = 1'b1; sin = exp[7 - (i % 8)];
      tick();
      if (i == 87) begin
        total++; if (sout !== 1'b0) begin bad++; $display("FAIL shift_half_sout got=%b want=0", sout); end
      end
    end
    sclk_en = 1'b0;
    total++; if (sout !== 1'b1) begin bad++; $display("FAIL shift_full_sout got=%b want=1", sout); end
    tick();
    total++; if (current_buffer !== exp) begin bad++; $display("FAIL shift_cb got=%h want=%h", current_buffer, exp); end
    sclk_en = 1'b1; sin = 1'b0;
    tick();
    total++; if (sout !== 1'b0) begin bad++; $display("FAIL shift_x1_sout got=%b want=0", sout); end
    tick();
    total++; if (sout !== 1'b1) begin bad++; $display("FAIL shift_x2_sout got=%b want=1", sout); end
    sclk_en = 1'b0;
    tick();
    total++; if (current_buffer[7:0] !== 8'h94) begin bad++; $display("FAIL shift_x_b0 got=%h want=94", current_buffer[7:0]); end
    total++; if (current_buffer[15:8] !== 8'h96) begin bad++; $display("FAIL shift_x_b1 got=%h want=96", current_buffer[15:8]); end
    total++; if (current_buffer[175:168] !== 8'h96) begin bad++; $display("FAIL shift_x_b21 got=%h want=96", current_buffer[175:168]); end
    ssel = 1'b0;
    #1;
    total++; if (sout !== 1'b0) begin bad++; $display("FAIL shift_nossel_sout got=%b want=0", sout); end
    idle();
  endtask

  task automatic test_field;
    bufp = 8'h04; fieldwp = 5'd5; field_in = 8'h3C; field_write = 1'b1; fieldp = 5'd5;
    tick();
    total++; if (field_byte !== 8'h00) begin bad++; $display("FAIL field_same_cycle got=%h want=00", field_byte); end
    field_write = 1'b0;
    tick();
    total++; if (field_byte !== 8'h3C) begin bad++; $display("FAIL field_read got=%h want=3c", field_byte); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL field_err got=%b want=0", sel_err); end
    buffer_select = 8'h04;
    tick();
    total++; if (current_buffer[5*8 +: 8] !== 8'h3C) begin bad++; $display("FAIL field_cb got=%h want=3c", current_buffer[5*8 +: 8]); end
  endtask

  task automatic test_back_to_back;
    bufp = 8'h02;
    for (int i = 0; i < 4; i++) begin
      fieldwp = 5'(i); fieldp = 5'(i); field_in = 8'(8'h10 + i); field_write = 1'b1;
      tick();
      total++; if (field_byte !== 8'h00) begin bad++; $display("FAIL b2b_old[%0d] got=%h want=00", i, field_byte); end
    end
    field_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fieldp = 5'(i);
      tick();
      total++; if (field_byte !== 8'(8'h10 + i)) begin bad++; $display("FAIL b2b_read[%0d] got=%h want=%h", i, field_byte, 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_collision;
    bufp = 8'h04; fieldwp = 5'd5; field_in = 8'h77; field_write = 1'b1; fieldp = 5'd5;
    ssel = 1'b1; saddr = 3'd2; sclk_en = 1'b1; sin = 1'b1;
    tick();
    idle();
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL coll_err got=%b want=1", sel_err); end
    total++; if (field_byte !== 8'h3C) begin bad++; $display("FAIL coll_old got=%h want=3c", field_byte); end
    tick();
    total++; if (field_byte !== 8'h77) begin bad++; $display("FAIL coll_write got=%h want=77", field_byte); end
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL coll_sticky got=%b want=1", sel_err); end
    fieldp = 5'd0;
    tick();
    total++; if (field_byte !== 8'h00) begin bad++; $display("FAIL coll_shift_lost got=%h want=00", field_byte); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL coll_clr got=%b want=0", sel_err); end
  endtask

  task automatic test_oob;
    bufp = 8'h04; fieldp = 5'd5;
    tick();
    fieldp = 5'd22;
    tick();
    total++; if (field_byte !== 8'h00) begin bad++; $display("FAIL oob_read got=%h want=00", field_byte); end
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL oob_read_err got=%b want=1", sel_err); end
    err_clr = 1'b1;
    tick();
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL oob_set_clr got=%b want=1", sel_err); end
    fieldp = 5'd5;
    tick();
    err_clr = 1'b0;
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL oob_clr got=%b want=0", sel_err); end
    fieldwp = 5'd22; field_in = 8'hFF; field_write = 1'b1;
    tick();
    field_write = 1'b0;
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL oob_write_err got=%b want=1", sel_err); end
    total++; if (field_byte !== 8'h77) begin bad++; $display("FAIL oob_write_nohit got=%h want=77", field_byte); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_onehot;
    bufp = 8'h01; fieldwp = 5'd0; field_in = 8'h11; field_write = 1'b1;
    tick();
    bufp = 8'h80; field_in = 8'h5A;
    tick();
    field_write = 1'b0; bufp = 8'h01; fieldp = 5'd0;
    buffer_select = 8'h80;
    tick();
    total++; if (current_buffer[7:0] !== 8'h5A) begin bad++; $display("FAIL oh_buf7 got=%h want=5a", current_buffer[7:0]); end
    buffer_select = 8'h03;
    tick();
`ifdef PATTERN_BANK_ONEHOT_CHECK_EN
    total++; if (current_buffer[7:0] !== 8'h5A) begin bad++; $display("FAIL oh_multi got=%h want=5a", current_buffer[7:0]); end
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL oh_multi_err got=%b want=1", sel_err); end
`else
    total++; if (current_buffer[7:0] !== 8'h11) begin bad++; $display("FAIL oh_multi got=%h want=11", current_buffer[7:0]); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL oh_multi_err got=%b want=0", sel_err); end
`endif
    buffer_select = 8'h00;
    tick();
    total++; if (current_buffer[7:0] !== (8'h5A)) begin bad++; $display("FAIL oh_zero got=%h want=5a", current_buffer[7:0]); end
    buffer_select = 8'h01; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_shift;
    logic [DEPTH*WIDTH-1:0] exp;
    exp = {DEPTH{8'hA5}};
    fieldwp = 5'd22; field_write = 1'b1;
    tick();
    field_write = 1'b0;
    buffer_select = 8'h20; bufp = 8'h20; fieldp = 5'd0;
    shift_in(3'd5, 8'hFF, 100);
    total++; if (field_byte !== 8'hFF) begin bad++; $display("FAIL mid_pre_fb got=%h want=ff", field_byte); end
    sclk_en = 1'b1; sin = 1'b1;
    rst_n = 1'b0;
    #1;
    total++; if (current_buffer !== {DEPTH*WIDTH{1'b0}}) begin bad++; $display("FAIL mid_rst_cb got=%h want=0", current_buffer); end
    total++; if (field_byte !== 8'h00) begin bad++; $display("FAIL mid_rst_fb got=%h want=00", field_byte); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%b want=0", sel_err); end
    total++; if (sout !== 1'b0) begin bad++; $display("FAIL mid_rst_sout got=%b want=0", sout); end
    tick();
    rst_n = 1'b1;
    shift_in(3'd5, 8'hA5, 176);
    tick();
    total++; if (current_buffer !== exp) begin bad++; $display("FAIL reshift_cb got=%h want=%h", current_buffer, exp); end
    idle();
    buffer_select = 8'h08;
    tick();
    total++; if (current_buffer !== {DEPTH*WIDTH{1'b0}}) begin bad++; $display("FAIL reset_cleared_b3 got=%h want=0", current_buffer); end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_field();
    test_back_to_back();
    test_collision();
    test_oob();
    test_onehot();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_bank.md
PATTERN_BANK -- requirements
Module: pattern_bank

Interface
REQ-001 Parameter WIDTH, default 8, bits per pattern byte.
REQ-002 Parameter DEPTH, default 22, bytes per buffer; legal 2..256.
REQ-003 Parameter NBUFS, default 8, buffer count; legal 2..16.
REQ-004 Derived widths SHALL be AW=clog2(DEPTH) for byte indices and SW=clog2(NBUFS) for buffer addresses.
REQ-005 Port clk, input, 1, sole clock, rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port sclk_en, input, 1, serial shift strobe, one bit per high cycle.
REQ-008 Port ssel, input, 1, serial interface enable.
REQ-009 Port saddr, input, SW, serial target buffer.
REQ-010 Port sin, input, 1, serial data in.
REQ-011 Port sout, output, 1, serial data out.
REQ-012 Port buffer_select, input, NBUFS, one-hot buffer for the current_buffer view.
REQ-013 Port current_buffer, output, DEPTH*WIDTH, registered image of the selected buffer; byte k at bits [k*WIDTH +: WIDTH].
REQ-014 Port bufp, input, NBUFS, one-hot buffer for field access.
REQ-015 Port fieldp, input, AW, field read index.
REQ-016 Port field_byte, output, WIDTH, registered read data.
REQ-017 Port fieldwp, input, AW, field write index.
REQ-018 Port field_in, input, WIDTH, write data.
REQ-019 Port field_write, input, 1, write strobe.
REQ-020 Port err_clr, input, 1, clears sel_err.
REQ-021 Port sel_err, output, 1, sticky error flag.

Function
REQ-022 Storage SHALL be NBUFS x DEPTH x WIDTH flops.
REQ-023 Serial shift: when ssel=1 and sclk_en=1, buffer saddr, viewed as {byte[DEPTH-1]..byte[0]}, SHALL shift left 1 bit with sin into byte[0] bit 0.
REQ-024 sout SHALL equal byte[DEPTH-1] bit WIDTH-1 of buffer saddr when ssel=1, else 0 (never Z).
REQ-025 Field write: when field_write=1, field_in SHALL be written into byte fieldwp of the buffer selected by bufp at the clock edge.
REQ-026 Write/shift collision on the same buffer: the write SHALL win, the shift SHALL be dropped, and sel_err SHALL set.
REQ-027 field_byte SHALL present byte fieldp of buffer bufp one cycle after sampling; same-cycle write to that byte returns the old data.
REQ-028 current_buffer SHALL update one cycle after the edge at which buffer_select is sampled, reflecting storage as of that edge.
REQ-029 fieldp or fieldwp >= DEPTH: the read SHALL return 0, the write SHALL be ignored, and sel_err SHALL set.
REQ-030 saddr >= NBUFS: the shift SHALL be ignored and sout SHALL be 0.
REQ-031 sel_err SHALL hold once set until err_clr=1; a simultaneous set and clear SHALL leave it set.

Reset
REQ-032 rst_n=0 SHALL immediately clear all storage, current_buffer, field_byte and sel_err to 0.
REQ-033 Reset mid-shift SHALL abort the shift; no partial data survives.
REQ-034 Operation SHALL resume on the first clk edge after rst_n rises.

Configuration
REQ-035 When macro PATTERN_BANK_ONEHOT_CHECK_EN is defined: zero or multi-hot buffer_select/bufp SHALL hold the affected output register, block the write, and set sel_err.
REQ-036 When PATTERN_BANK_ONEHOT_CHECK_EN is undefined: the lowest set bit SHALL win, all-zero SHALL select buffer NBUFS-1, and one-hot violations SHALL NOT set sel_err.

Verification
REQ-037 Shift 176 bits of 0xA5 bytes into saddr=3 with ssel=1 and buffer_select=8'h08 -> next cycle current_buffer is all 0xA5 and sout follows shifted data.
REQ-038 field_write with bufp=8'h04, fieldwp=5, field_in=0x3C, then read fieldp=5 -> field_byte=0x3C one cycle after the read; a same-cycle read returns old 0x00.
REQ-039 field_write and shift both targeting buffer 2 in one cycle -> written byte kept, shift lost, sel_err=1; err_clr -> sel_err=0.
REQ-040 fieldp=22 with DEPTH=22 -> field_byte=0 and sel_err=1.
REQ-041 buffer_select=8'h03: with CHECK_EN, current_buffer holds and sel_err=1; without it, buffer 0 is shown and sel_err=0.
REQ-042 rst_n asserted for 1 cycle midway through a shift -> all outputs 0 at once; a re-shift loads correctly.
